// File: rtl/i2c_slave_responder.sv
// I2C target: oversampled START/STOP detection, 7-bit address match, byte write/read.
// Latency: bus edges seen 2-3 ref_clk after the pad; rx_valid one ref_clk after the 8th SCL rise.
// Backpressure: none; tx_data must be valid whenever tx_req strobes, rx_valid cannot be stalled.
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
    input  logic       ref_clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ADDR   = 3'd1;
    localparam logic [2:0] IGNORE = 3'd2;
    localparam logic [2:0] ACK_A  = 3'd3;
    localparam logic [2:0] WR     = 3'd4;
    localparam logic [2:0] ACK_W  = 3'd5;
    localparam logic [2:0] RD     = 3'd6;
    localparam logic [2:0] RACK   = 3'd7;

    logic       scl_s1, scl_s2, scl_h;
    logic       sda_s1, sda_s2, sda_h;
    logic [2:0] state;
    logic [3:0] bit_cnt;
    logic [7:0] shift;
    logic       rw;

    logic       scl_rise, scl_fall, start, stop;
    logic [7:0] shift_in;

    assign scl_rise = scl_s2 & ~scl_h;
    assign scl_fall = ~scl_s2 & scl_h;
    // SCL must be stable high on both samples, so an SCL edge masks START/STOP.
    assign start    = scl_s2 & scl_h & sda_h & ~sda_s2;
    assign stop     = scl_s2 & scl_h & ~sda_h & sda_s2;
    assign shift_in = {shift[6:0], sda_s2};

    // Fabric supplies the next read byte on the falling edge that ends an ACK clock.
    assign tx_req = scl_fall && (bit_cnt == 4'd0) &&
                    (((state == ACK_A) && rw) || (state == RACK));

    always_ff @(posedge ref_clk) begin
        if (!rst_n) begin
            scl_s1   <= 1'b1;
            scl_s2   <= 1'b1;
            scl_h    <= 1'b1;
            sda_s1   <= 1'b1;
            sda_s2   <= 1'b1;
            sda_h    <= 1'b1;
            state    <= IDLE;
            bit_cnt  <= 4'd0;
            shift    <= 8'h00;
            rw       <= 1'b0;
            sda_oe   <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            scl_s1   <= scl_in;
            scl_s2   <= scl_s1;
            scl_h    <= scl_s2;
            sda_s1   <= sda_in;
            sda_s2   <= sda_s1;
            sda_h    <= sda_s2;
            rx_valid <= 1'b0;
            if (stop) begin
                state   <= IDLE;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
                bit_cnt <= 4'd0;
            end else if (start) begin
                state   <= ADDR;
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shift <= shift_in;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= 4'd8;
                                rw      <= sda_s2;
                                if (shift_in[7:1] == SLAVE_ADDR) begin
                                    state <= ACK_A;
                                    busy  <= 1'b1;
                                end else begin
                                    state <= IGNORE;
                                    busy  <= 1'b0;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    ACK_A, ACK_W: begin
                        // count 8: waiting to drive ACK; count 0: ACK clock has risen
                        if (scl_fall && (bit_cnt == 4'd8)) begin
                            sda_oe <= 1'b1;
                        end else if (scl_rise) begin
                            bit_cnt <= 4'd0;
                        end else if (scl_fall) begin
                            if ((state == ACK_A) && rw) begin
                                shift  <= tx_data;
                                sda_oe <= ~tx_data[7];
                                state  <= RD;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= WR;
                            end
                        end
                    end
                    WR: begin
                        if (scl_rise) begin
                            shift <= shift_in;
                            if (bit_cnt == 4'd7) begin
                                rx_data  <= shift_in;
                                rx_valid <= 1'b1;
                                bit_cnt  <= 4'd8;
                                state    <= ACK_W;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    RD: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                state  <= RACK;
                            end else begin
                                shift  <= {shift[6:0], 1'b0};
                                sda_oe <= ~shift[6];
                            end
                        end
                    end
                    RACK: begin
                        if (scl_rise) begin
                            bit_cnt <= 4'd0;
                            if (sda_s2) begin
                                state <= IGNORE;
                                busy  <= 1'b0;
                            end
                        end else if (scl_fall && (bit_cnt == 4'd0)) begin
                            shift  <= tx_data;
                            sda_oe <= ~tx_data[7];
                            state  <= RD;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench for i2c_slave_responder: bit-banged initiator on an open-drain SDA model.
// Latency: SCL quarter period is 8 ref_clk. Backpressure: none, fabric side always ready.
// Stimulus and sampling happen on ref_clk falling edges.
module tb_i2c_slave_responder;

    logic       ref_clk = 1'b0;
    logic       rst_n;
    logic       scl;
    logic       sda_m;
    logic [7:0] tx_data;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       busy;
    logic       sda_bus;

    int checks   = 0;
    int failures = 0;
    int rx_cnt   = 0;
    int tx_cnt   = 0;
    int busy_cyc = 0;
    int oe_cyc   = 0;
    int both_cyc = 0;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave_responder #(.SLAVE_ADDR(7'h42)) dut (
        .ref_clk  (ref_clk),
        .rst_n    (rst_n),
        .scl_in   (scl),
        .sda_in   (sda_bus),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .busy     (busy)
    );

    always #5 ref_clk = ~ref_clk;

    always @(posedge ref_clk) begin
        if (rx_valid) rx_cnt++;
        if (tx_req) tx_cnt++;
        if (busy) busy_cyc++;
        if (sda_oe) oe_cyc++;
        if (rx_valid && tx_req) both_cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic qwait();
        repeat (8) @(negedge ref_clk);
    endtask

    // Works both from idle (SCL high) and as a repeated START (SCL low).
    task automatic i2c_start();
        sda_m = 1'b1; qwait();
        scl   = 1'b1; qwait();
        sda_m = 1'b0; qwait();
        scl   = 1'b0; qwait();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; qwait();
        scl   = 1'b1; qwait();
        sda_m = 1'b1; qwait();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    qwait();
        scl   = 1'b1; qwait(); qwait();
        scl   = 1'b0; qwait();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; qwait();
        scl   = 1'b1; qwait();
        ack   = sda_bus; qwait();
        scl   = 1'b0; qwait();
    endtask

    task automatic read_byte(output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; qwait();
            scl   = 1'b1; qwait();
            b[i]  = sda_bus; qwait();
            scl   = 1'b0; qwait();
        end
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         rx0, tx0, busy0, oe0;

        rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1; tx_data = 8'h00;
        repeat (4) @(negedge ref_clk);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'h00);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_tx_req", 32'(tx_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        qwait();

        // 1: write 0xA5 to 0x42
        rx0 = rx_cnt;
        i2c_start();
        send_byte(8'h84, ack); chk("t1_addr_ack", 32'(ack), 32'd0);
        send_byte(8'hA5, ack); chk("t1_data_ack", 32'(ack), 32'd0);
        chk("t1_rx_data", 32'(rx_data), 32'hA5);
        chk("t1_rx_pulses", 32'(rx_cnt - rx0), 32'd1);
        chk("t1_busy_mid", 32'(busy), 32'd1);
        i2c_stop();
        chk("t1_busy_after", 32'(busy), 32'd0);

        // 2: wrong address is ignored entirely
        rx0 = rx_cnt; busy0 = busy_cyc; oe0 = oe_cyc;
        i2c_start();
        send_byte(8'h86, ack); chk("t2_addr_nack", 32'(ack), 32'd1);
        send_byte(8'h55, ack); chk("t2_data_nack", 32'(ack), 32'd1);
        i2c_stop();
        chk("t2_oe_cycles", 32'(oe_cyc - oe0), 32'd0);
        chk("t2_rx_pulses", 32'(rx_cnt - rx0), 32'd0);
        chk("t2_busy_cycles", 32'(busy_cyc - busy0), 32'd0);

        // 3: read two bytes, ACK then NACK
        tx0 = tx_cnt;
        tx_data = 8'h3C;
        i2c_start();
        send_byte(8'h85, ack); chk("t3_addr_ack", 32'(ack), 32'd0);
        chk("t3_tx_req1", 32'(tx_cnt - tx0), 32'd1);
        read_byte(rd); chk("t3_byte1", 32'(rd), 32'h3C);
        tx_data = 8'hC3;
        send_bit(1'b0);
        chk("t3_tx_req2", 32'(tx_cnt - tx0), 32'd2);
        read_byte(rd); chk("t3_byte2", 32'(rd), 32'hC3);
        send_bit(1'b1);
        chk("t3_busy_nack", 32'(busy), 32'd0);
        chk("t3_oe_released", 32'(sda_oe), 32'd0);
        i2c_stop();

        // 4: write 0x11, repeated START into a read
        rx0 = rx_cnt; tx0 = tx_cnt;
        i2c_start();
        send_byte(8'h84, ack); chk("t4_addr_ack", 32'(ack), 32'd0);
        send_byte(8'h11, ack); chk("t4_data_ack", 32'(ack), 32'd0);
        chk("t4_rx_data", 32'(rx_data), 32'h11);
        chk("t4_rx_pulses", 32'(rx_cnt - rx0), 32'd1);
        tx_data = 8'hF0;
        i2c_start();
        send_byte(8'h85, ack); chk("t4_raddr_ack", 32'(ack), 32'd0);
        chk("t4_busy", 32'(busy), 32'd1);
        chk("t4_tx_req", 32'(tx_cnt - tx0), 32'd1);
        read_byte(rd); chk("t4_read", 32'(rd), 32'hF0);
        send_bit(1'b1);
        i2c_stop();

        // 5: STOP mid-byte discards it; next write still received
        rx0 = rx_cnt;
        i2c_start();
        send_byte(8'h84, ack); chk("t5_addr_ack", 32'(ack), 32'd0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        i2c_stop();
        chk("t5_no_rx", 32'(rx_cnt - rx0), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_rx_data_kept", 32'(rx_data), 32'h11);
        i2c_start();
        send_byte(8'h84, ack); chk("t5_addr2_ack", 32'(ack), 32'd0);
        send_byte(8'h7E, ack); chk("t5_data_ack", 32'(ack), 32'd0);
        i2c_stop();
        chk("t5_rx_data", 32'(rx_data), 32'h7E);
        chk("t5_rx_pulses", 32'(rx_cnt - rx0), 32'd1);

        // 6: reset while driving a read 0 bit
        tx_data = 8'h3C;
        i2c_start();
        send_byte(8'h85, ack); chk("t6_addr_ack", 32'(ack), 32'd0);
        chk("t6_driving", 32'(sda_oe), 32'd1);
        rst_n = 1'b0;
        @(posedge ref_clk); #1;
        chk("t6_rst_oe", 32'(sda_oe), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_rx_data", 32'(rx_data), 32'h00);
        chk("t6_rst_tx_req", 32'(tx_req), 32'd0);
        @(negedge ref_clk);
        rst_n = 1'b1;
        sda_m = 1'b1; scl = 1'b1;
        qwait();
        i2c_start();
        send_byte(8'h84, ack); chk("t6_reacquire_ack", 32'(ack), 32'd0);
        i2c_stop();

        chk("no_rx_tx_overlap", 32'(both_cyc), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
